bcd_ex3_seq_converter: RTL and testbench

//  Multi-digit, mode-selectable BCD code converter; successor to the single-digit
//  bcd_exe3 combinational converter. Accepts a packed NDIGITS-digit BCD word over a

---
 rtl/bcd_ex3_pkg.sv | 21 ++
 rtl/bcd_digit_xlat.sv | 40 ++++
 rtl/bcd_ex3_seq_converter.sv | 112 +++++++++++
 tb/tb_bcd_ex3_seq_converter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_ex3_pkg.sv
// Shared definitions for the multi-digit BCD code converter: mode codes,
// FSM state encoding and BCD digit constants.
package bcd_ex3_pkg;

   localparam logic [1:0] MODE_EX3       = 2'd0;
   localparam logic [1:0] MODE_NINES     = 2'd1;
   localparam logic [1:0] MODE_EX3_NINES = 2'd2;
   localparam logic [1:0] MODE_TENS      = 2'd3;

   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam logic [3:0] EX3_OFFSET = 4'd3;
   localparam logic [3:0] DIGIT_BAD  = 4'hF;
   localparam logic [3:0] TENS_WRAP  = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_digit_xlat.sv
// Single-digit BCD translator: excess-3, 9's complement, excess-3 of the
// 9's complement, or one stage of a 10's-complement decimal carry chain.
module bcd_digit_xlat
   import bcd_ex3_pkg::*;
(
   input  logic [3:0] d,
   input  logic [1:0] mode,
   input  logic       cin,
   output logic [3:0] q,
   output logic       cout,
   output logic       bad
);

   logic [3:0] t;

   always_comb begin
      bad  = (d > BCD_MAX);
      q    = DIGIT_BAD;
      cout = 1'b0;
      t    = BCD_MAX - d + {3'b000, cin};
      // An invalid digit leaves q at DIGIT_BAD and kills the carry chain.
      if (!bad) begin
         case (mode)
            MODE_EX3:       q = d + EX3_OFFSET;
            MODE_NINES:     q = BCD_MAX - d;
            MODE_EX3_NINES: q = ~(d + EX3_OFFSET);
            MODE_TENS: begin
               if (t == TENS_WRAP) begin
                  q    = 4'd0;
                  cout = 1'b1;
               end else begin
                  q    = t;
               end
            end
            default:        q = DIGIT_BAD;
         endcase
      end
   end

endmodule

// File: rtl/bcd_ex3_seq_converter.sv
// Multi-digit BCD converter: captures a packed word over valid/ready and
// translates it one digit per clock, least-significant digit first.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for a word, in_ready high
//   ST_CONV | translating digit idx into out_data, NDIGITS cycles
//   ST_DONE | result presented with out_valid, held until out_ready
module bcd_ex3_seq_converter
   import bcd_ex3_pkg::*;
#(
   parameter int NDIGITS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NDIGITS-1:0]   in_bcd,
   input  logic [1:0]             in_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NDIGITS-1:0]   out_data,
   output logic                   out_err,
   output logic                   out_carry
);

   localparam int W     = 4 * NDIGITS;
   localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

   state_t           state;
   logic [W-1:0]     word_q;
   logic [1:0]       mode_q;
   logic [IDX_W-1:0] idx;
   logic             carry;

   logic [3:0]       d_cur;
   logic [3:0]       q_cur;
   logic             cout_cur;
   logic             bad_cur;

   always_comb begin
      d_cur = 4'd0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (idx == IDX_W'(i)) d_cur = word_q[4*i +: 4];
      end
   end

   bcd_digit_xlat u_xlat (
      .d    (d_cur),
      .mode (mode_q),
      .cin  (carry),
      .q    (q_cur),
      .cout (cout_cur),
      .bad  (bad_cur)
   );

   assign in_ready  = (state == ST_IDLE);
   // Non-TENS words start with carry 0 and the translator never raises it.
   assign out_carry = carry;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         word_q    <= '0;
         mode_q    <= MODE_EX3;
         idx       <= '0;
         carry     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  word_q  <= in_bcd;
                  mode_q  <= in_mode;
                  out_err <= 1'b0;
                  carry   <= (in_mode == MODE_TENS);
                  idx     <= '0;
                  state   <= ST_CONV;
               end
            end
            ST_CONV: begin
               for (int i = 0; i < NDIGITS; i++) begin
                  if (idx == IDX_W'(i)) out_data[4*i +: 4] <= q_cur;
               end
               if (bad_cur) out_err <= 1'b1;
               carry <= cout_cur;
               if (idx == LAST_IDX) begin
                  idx       <= '0;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_ex3_seq_converter.sv
// Self-checking bench for bcd_ex3_seq_converter: decimal-arithmetic reference
// model, per-cycle handshake/result checker and directed literal vectors.
module tb_bcd_ex3_seq_converter;

   localparam int NDIG = 4;
   localparam int W    = 4 * NDIG;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_bcd = '0;
   logic [1:0]   in_mode = 2'd0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_data;
   logic         out_err;
   logic         out_carry;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_ex3_seq_converter #(.NDIGITS(NDIG)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bcd    (in_bcd),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .out_carry (out_carry)
   );

   // Result packing: {carry, err, data}
   function automatic int pow10(input int n);
      int p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r = '0;
      int x = v;
      for (int i = 0; i < NDIG; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [W+1:0] model(input logic [W-1:0] w, input logic [1:0] m);
      int           v = 0;
      bit           bad = 0;
      bit           c;
      logic [W-1:0] r = '0;
      int           full = pow10(NDIG);
      for (int i = NDIG - 1; i >= 0; i--) begin
         int dg = int'((w >> (4*i)) & 16'hF);
         if (dg > 9) bad = 1;
         v = v * 10 + dg;
      end
      if (!bad) begin
         c = 0;
         case (m)
            2'd0: r = to_bcd(v) + {NDIG{4'h3}};
            2'd1: r = to_bcd(full - 1 - v);
            2'd2: r = to_bcd(full - 1 - v) + {NDIG{4'h3}};
            default: begin
               r = to_bcd((full - v) % full);
               c = (v == 0);
            end
         endcase
         return {c, 1'b0, r};
      end
      c = (m == 2'd3);
      for (int i = 0; i < NDIG; i++) begin
         int dg = int'((w >> (4*i)) & 16'hF);
         int t;
         if (dg > 9) begin
            r[4*i +: 4] = 4'hF;
            c = 0;
         end else begin
            case (m)
               2'd0: r[4*i +: 4] = 4'(dg + 3);
               2'd1: r[4*i +: 4] = 4'(9 - dg);
               2'd2: r[4*i +: 4] = 4'(12 - dg);
               default: begin
                  t = 9 - dg + int'(c);
                  if (t == 10) begin r[4*i +: 4] = 4'd0; c = 1; end
                  else begin r[4*i +: 4] = 4'(t); c = 0; end
               end
            endcase
         end
      end
      return {c, 1'b1, r};
   endfunction

   task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Scoreboard and in-flight tracking, updated at the active edge
   logic [W+1:0] exp_q[$];
   bit           busy = 0;
   int           cyc = 0;
   int           acc_cyc = 0;
   int           got_count = 0;
   logic [W+1:0] last_res = '0;
   bit           hold_pending = 0;
   bit           prev_valid = 0;
   logic [W+1:0] held = '0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         busy = 0;
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) busy = 0;
         if (in_valid && in_ready) begin
            busy    = 1;
            acc_cyc = cyc;
            exp_q.push_back(model(in_bcd, in_mode));
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         hold_pending = 0;
         prev_valid   = 0;
      end else begin
         check("in_ready_vs_busy", {{(W+1){1'b0}}, in_ready}, {{(W+1){1'b0}}, !busy});
         if (out_valid && exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_out_valid: out_valid=1 with no word outstanding (t=%0t)", $time);
         end
         if (hold_pending) begin
            check("hold_valid", {{(W+1){1'b0}}, out_valid}, {{(W+1){1'b0}}, 1'b1});
            check("hold_data", {out_carry, out_err, out_data}, held);
         end
         if (out_valid && !prev_valid)
            check("latency", (W+2)'(cyc - acc_cyc), (W+2)'(NDIG));
         if (out_valid && out_ready && exp_q.size() != 0) begin
            check("result", {out_carry, out_err, out_data}, exp_q.pop_front());
            last_res = {out_carry, out_err, out_data};
            got_count++;
         end
         hold_pending = out_valid && !out_ready;
         held         = {out_carry, out_err, out_data};
         prev_valid   = out_valid;
      end
   end

   task automatic send(input logic [W-1:0] w, input logic [1:0] m);
      int n = 0;
      in_bcd   = w;
      in_mode  = m;
      in_valid = 1'b1;
      while (!in_ready && n < 40) begin @(posedge clk); #2; n++; end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
      end
      @(posedge clk); #2;
      in_valid = 1'b0;
      in_bcd   = ~w;
      in_mode  = ~m;
   endtask

   task automatic wait_result(input int n0);
      int n = 0;
      while (got_count == n0 && n < 40) begin @(posedge clk); #2; n++; end
      if (got_count == n0) begin
         checks++; errors++;
         $display("FAIL result_timeout: no result after %0d cycles", n);
      end
   endtask

   task automatic run_word(input logic [W-1:0] w, input logic [1:0] m,
                           input logic [W-1:0] ed, input logic ee, input logic ec);
      int n0;
      check("model_pin", model(w, m), {ec, ee, ed});
      n0 = got_count;
      send(w, m);
      wait_result(n0);
      check("literal", last_res, {ec, ee, ed});
   endtask

   initial begin
      int n0;
      int n;
      logic [W-1:0] rw;
      repeat (2) @(posedge clk);
      #2;
      check("reset_outs", {out_valid, in_ready, out_err, out_carry}, {1'b0, 1'b1, 1'b0, 1'b0});
      check("reset_data", {2'b00, out_data}, '0);
      rst = 1'b0;
      @(posedge clk); #2;

      run_word(16'h1234, 2'd0, 16'h4567, 1'b0, 1'b0);
      run_word(16'h0925, 2'd1, 16'h9074, 1'b0, 1'b0);
      run_word(16'h0009, 2'd2, 16'hCCC3, 1'b0, 1'b0);
      run_word(16'h0250, 2'd3, 16'h9750, 1'b0, 1'b0);
      run_word(16'h0000, 2'd3, 16'h0000, 1'b0, 1'b1);
      run_word(16'h12A4, 2'd0, 16'h45F7, 1'b1, 1'b0);
      run_word(16'h0000, 2'd0, 16'h3333, 1'b0, 1'b0);
      run_word(16'h1B00, 2'd3, 16'h8F00, 1'b1, 1'b0);
      run_word(16'h9990, 2'd3, 16'h0010, 1'b0, 1'b0);

      // Back-pressure in DONE
      out_ready = 1'b0;
      n0 = got_count;
      send(16'h4321, 2'd1);
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #2; n++; end
      check("stall_reach_done", {{(W+1){1'b0}}, out_valid}, {{(W+1){1'b0}}, 1'b1});
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_bcd   = 16'h1111;
         in_mode  = 2'd0;
         @(posedge clk); #2;
         check("stall_state", {{(W-1){1'b0}}, in_ready, out_valid, out_err},
               {{(W-1){1'b0}}, 1'b0, 1'b1, 1'b0});
         check("stall_data", {2'b00, out_data}, {2'b00, 16'h5678});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #2;
      check("release", {{(W){1'b0}}, in_ready, out_valid}, {{(W){1'b0}}, 1'b1, 1'b0});
      check("release_count", (W+2)'(got_count - n0), (W+2)'(1));

      // Reset during the second conversion cycle
      n0 = got_count;
      send(16'h5678, 2'd0);
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      check("rst_mid_conv", {{(W){1'b0}}, in_ready, out_valid}, {{(W){1'b0}}, 1'b1, 1'b0});
      check("rst_mid_data", {2'b00, out_data}, '0);
      repeat (8) @(posedge clk);
      #2;
      check("rst_no_result", (W+2)'(got_count - n0), '0);
      run_word(16'h9999, 2'd1, 16'h0000, 1'b0, 1'b0);

      // Mixed words checked against the model only
      for (int k = 0; k < 16; k++) begin
         rw = '0;
         for (int i = 0; i < NDIG; i++)
            rw[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
         n0 = got_count;
         send(rw, 2'($urandom_range(0, 3)));
         wait_result(n0);
      end

      repeat (3) @(posedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
